fifo_uart_tx: RTL

//  Downstream drain stage for the FIFO: pops one word at a time and transmits it as an

---
 rtl/fifo_uart_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and sends it as an async serial frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Enable,
  input  logic                  Fifo_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Data,
  output logic                  Fifo_Read,
  output logic                  Tx,
  output logic                  Busy,
  output logic                  Frame_Done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BAUD_W-1:0]     baud;
  logic                  baud_last;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  assign shreg_nxt = shreg >> 1;
  assign baud_last = (baud == BAUD_LAST);

  // Tx, Fifo_Read, Busy and Frame_Done are all driven from this register block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      Tx         <= 1'b1;
      Fifo_Read  <= 1'b0;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      baud       <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      Fifo_Read  <= 1'b0;
      Frame_Done <= 1'b0;
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (Enable && !Fifo_Empty) begin
            state     <= FETCH;
            Fifo_Read <= 1'b1;
            Busy      <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shreg   <= Fifo_Data;
`ifdef UART_TX_PARITY_EN
          parity_bit <= even_parity(Fifo_Data);
`endif
          bit_cnt <= '0;
          baud    <= '0;
          Tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (baud_last) begin
            baud  <= '0;
            Tx    <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud  <= '0;
            shreg <= shreg_nxt;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              Tx    <= parity_bit;
              state <= PARITY;
`else
              Tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              Tx      <= shreg_nxt[0];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud  <= '0;
            Tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          // Registered pulse: raised one edge early so it lands on the stop bit's last clk
          if (baud == BAUD_PRE) Frame_Done <= 1'b1;
          if (baud_last) begin
            baud  <= '0;
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          Tx    <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
